// File: rtl/maze_port_arbiter.sv
// maze_port_arbiter
//   Shares the single synchronous maze memory port between two requesters.
//   One access is issued at a time. The memory-side address and enables are
//   registered, and read data comes back on a shared rdata with a per-requester
//   rvalid strobe.
//
//   Build option: define MAZE_ARB_RR_EN for round-robin arbitration.
//   If it is left undefined, requester 0 has fixed priority.
//
//   Ports
//     clk, rst              clock, asynchronous active-high reset
//     req0/1                access request, held until the matching gnt is seen
//     row0/1, col0/1        target cell of each requester
//     we0/1                 1 = write (mark cell), 0 = read
//     gnt0/1                one-cycle pulse when that requester's access issues
//     rvalid0/1             one-cycle pulse when rdata holds that requester's result
//     rdata                 registered copy of maze_in
//     busy                  high whenever the arbiter is not idle
//     row, col              registered address to the maze memory
//     maze_oe, maze_we      registered read/write enables to the memory
//     maze_in               memory read data, valid the cycle after maze_oe is sampled
module maze_port_arbiter #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] row0,
    input  logic [ADDR_W-1:0] col0,
    input  logic              we0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] row1,
    input  logic [ADDR_W-1:0] col1,
    input  logic              we1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic              rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] row,
    output logic [ADDR_W-1:0] col,
    output logic              maze_oe,
    output logic              maze_we,
    input  logic              maze_in
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e state_q;
    logic   op_we_q;    // recorded operation of the access in flight
    logic   winner_q;   // recorded winner, steers rvalid
    logic   pick1;      // 1 = requester 1 wins the current IDLE sample

`ifdef MAZE_ARB_RR_EN
    logic last_q;       // last granted requester; reset to 1 so requester 0 is preferred

    always_comb begin
        pick1 = 1'b0;
        if (req0 && req1) begin
            pick1 = ~last_q;
        end else begin
            pick1 = req1;
        end
    end
`else
    always_comb begin
        pick1 = req1 & ~req0;
    end
`endif

    assign busy = (state_q != StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            op_we_q  <= 1'b0;
            winner_q <= 1'b0;
            row      <= '0;
            col      <= '0;
            maze_oe  <= 1'b0;
            maze_we  <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rdata    <= 1'b0;
`ifdef MAZE_ARB_RR_EN
            last_q   <= 1'b1;
`endif
        end else begin
            // Grant and valid strobes are single-cycle pulses.
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (req0 || req1) begin
                        winner_q <= pick1;
`ifdef MAZE_ARB_RR_EN
                        last_q   <= pick1;
`endif
                        if (pick1) begin
                            row     <= row1;
                            col     <= col1;
                            maze_we <= we1;
                            maze_oe <= ~we1;
                            op_we_q <= we1;
                            gnt1    <= 1'b1;
                        end else begin
                            row     <= row0;
                            col     <= col0;
                            maze_we <= we0;
                            maze_oe <= ~we0;
                            op_we_q <= we0;
                            gnt0    <= 1'b1;
                        end
                        state_q <= StAccess;
                    end
                end

                StAccess: begin
                    // Memory samples the enables on this edge.
                    // row/col keep their value until the next grant.
                    maze_oe <= 1'b0;
                    maze_we <= 1'b0;
                    state_q <= op_we_q ? StIdle : StResp;
                end

                StResp: begin
                    rdata   <= maze_in;
                    rvalid0 <= ~winner_q;
                    rvalid1 <= winner_q;
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maze_port_arbiter.sv
// Directed and random-traffic bench for maze_port_arbiter with a small
// behavioural maze memory. A cell reads 1 if it was written, or if its row
// and column are both odd.
module tb_maze_port_arbiter;

    localparam int unsigned AW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [AW-1:0] row0 = '0, col0 = '0, row1 = '0, col1 = '0;
    logic          we0 = 1'b0, we1 = 1'b0;
    logic          gnt0, gnt1, rvalid0, rvalid1, rdata, busy;
    logic [AW-1:0] row, col;
    logic          maze_oe, maze_we;
    logic          maze_in;

    logic          wr_mem [64][64];

    int total = 0;
    int bad   = 0;

    maze_port_arbiter #(
        .ADDR_W(AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .row0    (row0),
        .col0    (col0),
        .we0     (we0),
        .req1    (req1),
        .row1    (row1),
        .col1    (col1),
        .we1     (we1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .rvalid0 (rvalid0),
        .rvalid1 (rvalid1),
        .rdata   (rdata),
        .busy    (busy),
        .row     (row),
        .col     (col),
        .maze_oe (maze_oe),
        .maze_we (maze_we),
        .maze_in (maze_in)
    );

    always #5 clk = ~clk;

    // Maze memory model: synchronous oe/we, read data the cycle after oe.
    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 64; r++) begin
                for (int c = 0; c < 64; c++) begin
                    wr_mem[r][c] <= 1'b0;
                end
            end
            maze_in <= 1'b0;
        end else begin
            if (maze_oe) maze_in <= wr_mem[row][col] | (row[0] & col[0]);
            if (maze_we) wr_mem[row][col] <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},    32'({gnt0, gnt1}), 0);
        check({tag, "_rvalid"}, 32'({rvalid0, rvalid1}), 0);
        check({tag, "_rdata"},  32'(rdata), 0);
        check({tag, "_busy"},   32'(busy), 0);
        check({tag, "_addr"},   32'({row, col}), 0);
        check({tag, "_en"},     32'({maze_oe, maze_we}), 0);
    endtask

    // One read by requester sel with its full timing checked.
    task automatic do_read(input logic sel, input logic [AW-1:0] r, input logic [AW-1:0] c,
                           input logic exp);
        @(negedge clk);
        if (sel) begin
            req1 = 1'b1; we1 = 1'b0; row1 = r; col1 = c;
        end else begin
            req0 = 1'b1; we0 = 1'b0; row0 = r; col0 = c;
        end
        @(negedge clk);
        check("rd_gnt",  32'({gnt1, gnt0}), sel ? 32'd2 : 32'd1);
        check("rd_addr", 32'({row, col}), 32'({r, c}));
        check("rd_en",   32'({maze_oe, maze_we}), 32'd2);
        check("rd_busy", 32'(busy), 1);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        check("rd_resp_rvalid", 32'({rvalid1, rvalid0}), 0);
        check("rd_resp_en",     32'({maze_oe, maze_we}), 0);
        @(negedge clk);
        check("rd_rvalid", 32'({rvalid1, rvalid0}), sel ? 32'd2 : 32'd1);
        check("rd_rdata",  32'(rdata), 32'(exp));
        check("rd_idle",   32'(busy), 0);
        @(negedge clk);
        check("rd_rvalid_pulse", 32'({rvalid1, rvalid0}), 0);
    endtask

    task automatic do_write(input logic sel, input logic [AW-1:0] r, input logic [AW-1:0] c);
        @(negedge clk);
        if (sel) begin
            req1 = 1'b1; we1 = 1'b1; row1 = r; col1 = c;
        end else begin
            req0 = 1'b1; we0 = 1'b1; row0 = r; col0 = c;
        end
        @(negedge clk);
        check("wr_gnt",  32'({gnt1, gnt0}), sel ? 32'd2 : 32'd1);
        check("wr_addr", 32'({row, col}), 32'({r, c}));
        check("wr_en",   32'({maze_oe, maze_we}), 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        check("wr_en_off", 32'({maze_oe, maze_we}), 0);
        check("wr_busy",   32'(busy), 0);
        check("wr_rvalid", 32'({rvalid1, rvalid0}), 0);
        @(negedge clk);
        check("wr_rvalid2", 32'({rvalid1, rvalid0}), 0);
    endtask

    logic p0_1, p0_2, p1_1, p1_2;
    logic e0, e1;

    initial begin
        // Reset state
        @(negedge clk);
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        // Single reads and writes
        do_read(1'b0, 6'd5, 6'd7, 1'b1);
        do_read(1'b1, 6'd2, 6'd4, 1'b0);
        do_write(1'b1, 6'd63, 6'd0);
        check("addr_hold", 32'({row, col}), 32'({6'd63, 6'd0}));
        do_read(1'b0, 6'd63, 6'd0, 1'b1);

        // Tie, starting from reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req0 = 1'b1; we0 = 1'b0; row0 = 6'd1; col0 = 6'd1;
        req1 = 1'b1; we1 = 1'b0; row1 = 6'd2; col1 = 6'd2;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
`ifdef MAZE_ARB_RR_EN
            e0 = (k % 3 == 1) && ((k / 3) % 2 == 0);
            e1 = (k % 3 == 1) && ((k / 3) % 2 == 1);
`else
            e0 = (k % 3 == 1);
            e1 = 1'b0;
`endif
            check("tie_gnt0", 32'(gnt0), 32'(e0));
            check("tie_gnt1", 32'(gnt1), 32'(e1));
        end
        // Arbiter is idle now; drop req0 and requester 1 must be granted.
        req0 = 1'b0;
        @(negedge clk);
        check("tie_gnt1_after_drop", 32'({gnt1, gnt0}), 32'd2);
        req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("tie_rvalid1", 32'({rvalid1, rvalid0}), 32'd2);
        check("tie_rdata",   32'(rdata), 0);
        @(negedge clk);

        // Reset during RESP
        req0 = 1'b1; we0 = 1'b0; row0 = 6'd5; col0 = 6'd7;
        @(negedge clk);
        check("rr_gnt0", 32'(gnt0), 1);
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("rst_resp");
        @(negedge clk);
        check("rst_resp_rvalid", 32'(rvalid0), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_after_rvalid", 32'(rvalid0), 0);
        check("rst_after_busy",   32'(busy), 0);
        req0 = 1'b1; we0 = 1'b0;
        req1 = 1'b1; we1 = 1'b0;
        @(negedge clk);
        check("rst_tie_gnt", 32'({gnt1, gnt0}), 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);

        // Random traffic with exclusion and rvalid bookkeeping
        p0_1 = 1'b0; p0_2 = 1'b0; p1_1 = 1'b0; p1_2 = 1'b0;
        for (int k = 0; k < 10000; k++) begin
            @(negedge clk);
            check("rnd_excl", 32'({maze_oe & maze_we, gnt0 & gnt1, rvalid0 & rvalid1}), 0);
            check("rnd_rv0",  32'(rvalid0), 32'(p0_2));
            check("rnd_rv1",  32'(rvalid1), 32'(p1_2));
            p0_2 = p0_1; p0_1 = gnt0 & maze_oe;
            p1_2 = p1_1; p1_1 = gnt1 & maze_oe;
            if (gnt0 || !req0) begin
                req0 = 1'($urandom_range(2) == 0);
                we0  = 1'($urandom_range(1));
                row0 = 6'($urandom_range(63));
                col0 = 6'($urandom_range(63));
            end
            if (gnt1 || !req1) begin
                req1 = 1'($urandom_range(2) == 0);
                we1  = 1'($urandom_range(1));
                row1 = 6'($urandom_range(63));
                col1 = 6'($urandom_range(63));
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
